// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl
// Sequencer for an external serial-in shift-register chain. It accepts one
// parallel word over a valid/ready handshake and sends it bit by bit onto the
// chain. Each bit is held for DIV cycles and gets one shift strobe. A single
// latch pulse follows the last strobe.
//
// Parameters
//   WIDTH : bits per word and number of strobes per transfer (>= 2)
//   DIV   : clock cycles per bit period (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   producer offers in_data
//   in_ready   out  controller idle and able to accept a word
//   in_data    in   word to serialize
//   msb_first  in   bit order, sampled at accept (1 = bit WIDTH-1 first)
//   sh_d       out  serial data to the chain input
//   sh_en      out  shift strobe; the chain captures sh_d at the end of this cycle
//   sh_q       in   serial return from the chain tail (read-back only)
//   latch      out  one-cycle pulse after the last shift
//   busy       out  transfer in progress
//   rd_data    out  word read back from the chain (read-back only)
//
// Optional feature, enabled by defining SHIFT_CHAIN_CTRL_READBACK_EN:
//   sh_q is sampled on every strobe. The sampled word appears on rd_data in
//   the LATCH cycle. When the macro is undefined, rd_data is tied to zero.

module shift_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             sh_d,
    output logic             sh_en,
    input  logic             sh_q,
    output logic             latch,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1'b1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [BW-1:0]    bit_cnt_r;
    logic [DW-1:0]    div_cnt_r;
    logic [WIDTH-1:0] shadow_r;
    logic             accept_s;
    logic             strobe_s;
    logic             last_s;

    // Reverse bit order so the shadow can always shift out from its MSB.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Handshake and strobe decode from state and counters.
    always_comb begin
        accept_s = 1'b0;
        strobe_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = in_valid;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_SHIFT) begin
            strobe_s = (div_cnt_r == DIV_LAST);
            last_s   = (div_cnt_r == DIV_LAST) && (bit_cnt_r == BIT_LAST);
        end else begin
            strobe_s = 1'b0;
            last_s   = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_LATCH: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output decode; everything is a function of registered state only.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        sh_en    = 1'b0;
        latch    = 1'b0;
        sh_d     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                sh_en = strobe_s;
                sh_d  = shadow_r[WIDTH-1];
            end
            ST_LATCH: begin
                busy  = 1'b1;
                latch = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shadow word and bit/period counters. The shadow is stored in send order,
    // so the current bit is always its MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= {BW{1'b0}};
            div_cnt_r <= {DW{1'b0}};
            shadow_r  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            bit_cnt_r <= {BW{1'b0}};
            div_cnt_r <= {DW{1'b0}};
            shadow_r  <= msb_first ? in_data : bit_reverse(in_data);
        end else if (strobe_s) begin
            div_cnt_r <= {DW{1'b0}};
            bit_cnt_r <= last_s ? {BW{1'b0}} : (bit_cnt_r + BIT_ONE);
            shadow_r  <= {shadow_r[WIDTH-2:0], 1'b0};
        end else if (state_r == ST_SHIFT) begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

`ifdef SHIFT_CHAIN_CTRL_READBACK_EN
    logic             rb_msb_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] cap_s;

    // Insert the returning bit so that the first sample lands on the same
    // bit position it was transmitted from.
    always_comb begin
        cap_s = cap_r;
        if (rb_msb_r) begin
            cap_s = {cap_r[WIDTH-2:0], sh_q};
        end else begin
            cap_s = {sh_q, cap_r[WIDTH-1:1]};
        end
    end

    // Capture on each strobe and publish the whole word at once on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_msb_r <= 1'b0;
            cap_r    <= {WIDTH{1'b0}};
            rd_data  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            rb_msb_r <= msb_first;
            cap_r    <= {WIDTH{1'b0}};
        end else if (strobe_s) begin
            cap_r <= cap_s;
            if (last_s) begin
                rd_data <= cap_s;
            end
        end
    end
`else
    assign rd_data = {WIDTH{1'b0}};
`endif

endmodule

// File: doc/shift_chain_ctrl.md
Name: shift_chain_ctrl

Overview:
Sequencer for an external serial-in shift-register chain of flip-flops clocked by the system clock.
- Accepts a parallel word over a valid/ready handshake and serializes it onto the chain's data input.
- Issues one shift-enable strobe per bit at a programmable rate, then a one-cycle latch pulse.
- Sits between a word-level producer and the shift datapath, so the datapath never sees back-to-back or partial words.

Parameters:
WIDTH, 8, bits per word / number of shift strobes per transfer (>=2)
DIV, 2, clock cycles per bit period (>=1); DIV=1 gives one bit per cycle

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  producer has a word on in_data
in_ready  out  1  controller can accept a word
in_data  in  WIDTH  word to serialize
msb_first  in  1  bit order, sampled at accept (1 = bit WIDTH-1 first)
sh_d  out  1  serial data to chain input
sh_en  out  1  one-cycle shift strobe; chain captures sh_d on the edge ending this cycle
sh_q  in  1  serial return from chain tail (used only with optional feature)
latch  out  1  one-cycle pulse after last shift
busy  out  1  transfer in progress
rd_data  out  WIDTH  read-back word (optional feature)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- rst_n low, asynchronously: state=IDLE; sh_d, sh_en, latch, busy = 0; rd_data = 0; counters = 0; in_ready reads 1.
- Reset mid-transfer aborts immediately. No latch is issued and the partial word is discarded.
- States:
  - IDLE: in_ready=1, busy=0, sh_d=0. If in_valid=1 at an edge, capture in_data and msb_first into a shadow register, clear bit_cnt and div_cnt, and go to SHIFT.
  - SHIFT: in_ready=0, busy=1. sh_d = current bit (msb_first: shadow[WIDTH-1-bit_cnt], else shadow[bit_cnt]), held stable for DIV cycles. div_cnt counts 0..DIV-1. sh_en=1 only when div_cnt==DIV-1. On that cycle div_cnt wraps to 0 and bit_cnt increments. When the strobe for bit_cnt==WIDTH-1 fires, go to LATCH.
  - LATCH: latch=1, busy=1, in_ready=0, sh_d=0, sh_en=0, for exactly one cycle, then go to IDLE.
- Timing:
  - Accept edge = cycle 0. Strobe n (0-based) is asserted in cycle (n+1)*DIV. Latch is asserted in cycle WIDTH*DIV+1.
  - Earliest next accept is at the edge ending the first IDLE cycle after LATCH. Throughput = WIDTH*DIV+2 cycles per word.
- Changes on in_data, in_valid or msb_first while busy are ignored. A held in_valid is accepted on the first IDLE cycle.
- Counters are sized clog2(WIDTH) and clog2(DIV) bits (minimum 1). No other wrap-around is reachable.
- All outputs are registered or decoded directly from state and counters. There are no combinational paths from inputs to outputs except in_ready (state only).

Optional Feature:
Macro: SHIFT_CHAIN_CTRL_READBACK_EN
- Defined:
  - sh_q is sampled on every cycle where sh_en=1.
  - Sampled bits fill rd_data in the same order as transmission: with msb_first=1 the first sample goes to bit WIDTH-1, otherwise to bit 0.
  - rd_data is updated atomically and becomes visible in the LATCH cycle. It then holds until the next LATCH or reset.
- Undefined: sh_q is ignored; rd_data is constant 0; no read-back logic is synthesized. The port list is identical in both builds.

Test Plan:
1. Reset, then WIDTH=8, DIV=2, in_data=8'hC1, msb_first=1 -> sh_d bit sequence 1,1,0,0,0,0,0,1, each bit held 2 cycles; sh_en pulses in cycles 2,4,...,16; latch=1 only in cycle 17; in_ready=1 again in cycle 18.
2. Same word with msb_first=0 -> sh_d sequence 1,0,0,0,0,0,1,1; identical strobe and latch timing.
3. DIV=1, in_valid held high with in_data=8'h5A then 8'h3C -> sh_en high in cycles 1..8, latch in cycle 9, second word accepted at the end of cycle 10; in_data changes during SHIFT have no effect on sh_d.
4. rst_n pulled low in cycle 7 of a DIV=2 transfer -> all outputs 0 and in_ready=1 within the same cycle (asynchronous); no latch pulse; a new word after release transfers cleanly.
5. READBACK_EN, 8-bit chain model fed back into sh_q, preloaded with 8'hFF, then send 8'h00 msb_first=1 -> rd_data=8'hFF at latch. A second send of 8'hA5 -> rd_data=8'h00.
6. READBACK_EN undefined, same stimulus as scenario 5 -> rd_data stays 8'h00; all other outputs match scenario 5 cycle for cycle.
